// File: rtl/tap_chain.sv
// Programmable delay line: STAGES chained register stages with per-stage valid,
// shift enable, synchronous flush, saturating fill counter and a runtime output tap.

// One delay stage: data word plus its valid flag.
module tap_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Stage register: clear drops only the valid flag, the data word is kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= din;
      valid_q <= din_valid;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;

endmodule

module tap_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 4,
  parameter int unsigned SEL_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [SEL_W-1:0] fill,
  output logic             full
);

  localparam logic [SEL_W-1:0] FillMax = SEL_W'(STAGES);

  // Index 0 is the chain input, index k the output of stage k.
  logic [WIDTH-1:0] tap_data  [STAGES+1];
  logic             tap_valid [STAGES+1];

  logic             load;
  logic [SEL_W-1:0] fill_q, fill_d;

  // Flush has priority over the shift enable.
  assign load = en & ~flush;

  assign tap_data[0]  = d;
  assign tap_valid[0] = d_valid;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    tap_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .resetn     (resetn),
      .load       (load),
      .clear      (flush),
      .din        (tap_data[k-1]),
      .din_valid  (tap_valid[k-1]),
      .dout       (tap_data[k]),
      .dout_valid (tap_valid[k])
    );
  end

  // Tap mux; out-of-range selects read as zero.
  always_comb begin
    q       = '0;
    q_valid = 1'b0;
    for (int k = 0; k <= STAGES; k++) begin
      if (sel == SEL_W'(k)) begin
        q       = tap_data[k];
        q_valid = tap_valid[k];
      end
    end
  end

  // Fill counts accepted valid words, saturating at STAGES.
  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = '0;
    end else if (en && d_valid && (fill_q != FillMax)) begin
      fill_d = fill_q + SEL_W'(1);
    end
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
  assign full = (fill_q == FillMax);

endmodule

// File: tb/tb_tap_chain.sv
// Scoreboard bench for tap_chain: a 4-stage and a 5-stage instance share all
// stimulus and are checked against a history-queue reference model.
module tb_tap_chain;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] d = 8'h00;
  logic       d_valid = 1'b0;
  logic [2:0] sel = 3'd0;

  logic [7:0] q4, q5;
  logic       qv4, qv5;
  logic [2:0] fill4, fill5;
  logic       full4, full5;

  always #5 clk = ~clk;

  tap_chain #(.WIDTH(8), .STAGES(4)) dut4 (
    .clk(clk), .resetn(resetn), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .sel(sel), .q(q4), .q_valid(qv4), .fill(fill4), .full(full4)
  );

  tap_chain #(.WIDTH(8), .STAGES(5)) dut5 (
    .clk(clk), .resetn(resetn), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .sel(sel), .q(q5), .q_valid(qv5), .fill(fill5), .full(full5)
  );

  typedef struct {
    logic [7:0] q4;
    logic       qv4;
    logic [2:0] f4;
    logic       fu4;
    logic [7:0] q5;
    logic       qv5;
    logic [2:0] f5;
    logic       fu5;
  } exp_t;

  exp_t exp_q[$];

  // Model: most recent shifted word at index 0; entries beyond 5 are dropped.
  logic [7:0] hd[$];
  bit         hv[$];
  int         m_fill4 = 0;
  int         m_fill5 = 0;

  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] tap(int s, logic [2:0] k);
    if (k == 3'd0) return {d_valid, d};
    if (int'(k) > s) return 9'd0;
    if (int'(k) <= hd.size()) return {hv[k-1], hd[k-1]};
    return 9'd0;
  endfunction

  task automatic step(input logic e, input logic f, input logic [7:0] dd, input logic dv,
                      input logic [2:0] s, input logic r);
    exp_t x;
    logic [8:0] t4, t5;
    @(negedge clk);
    en = e; flush = f; d = dd; d_valid = dv; sel = s; resetn = r;
    if (!r) begin
      hd.delete(); hv.delete(); m_fill4 = 0; m_fill5 = 0;
    end
    #1;
    t4 = tap(4, s);
    t5 = tap(5, s);
    x.q4 = t4[7:0]; x.qv4 = t4[8]; x.f4 = 3'(m_fill4); x.fu4 = (m_fill4 == 4);
    x.q5 = t5[7:0]; x.qv5 = t5[8]; x.f5 = 3'(m_fill5); x.fu5 = (m_fill5 == 5);
    exp_q.push_back(x);
    // Apply the coming edge to the model.
    if (r) begin
      if (f) begin
        foreach (hv[i]) hv[i] = 1'b0;
        m_fill4 = 0; m_fill5 = 0;
      end else if (e) begin
        hd.push_front(dd); hv.push_front(dv);
        if (hd.size() > 5) begin
          void'(hd.pop_back()); void'(hv.pop_back());
        end
        if (dv) begin
          if (m_fill4 < 4) m_fill4++;
          if (m_fill5 < 5) m_fill5++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h (sel=%0d)", name, $time, act, req, sel);
    end
  endtask

  // Monitor: compares each presented cycle against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("q4", 32'(q4), 32'(x.q4));
        chk("q_valid4", 32'(qv4), 32'(x.qv4));
        chk("fill4", 32'(fill4), 32'(x.f4));
        chk("full4", 32'(full4), 32'(x.fu4));
        chk("q5", 32'(q5), 32'(x.q5));
        chk("q_valid5", 32'(qv5), 32'(x.qv5));
        chk("fill5", 32'(fill5), 32'(x.f5));
        chk("full5", 32'(full5), 32'(x.fu5));
      end
    end
  end

  initial begin
    logic [7:0] seq [4];
    int budget;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    // Reset held: every tap must read zero while data is presented.
    for (int s = 0; s <= 7; s++) step(1'b1, 1'b0, 8'hFF, 1'b1, 3'(s), 1'b0);

    // Delay through sel=3, then a few idle shifts to watch the words pass.
    foreach (seq[i]) step(1'b1, 1'b0, seq[i], 1'b1, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1);

    // Stall with en=0, then resume.
    step(1'b1, 1'b0, 8'hA5, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h3C, 1'b1, 3'd1, 1'b1);
    for (int s = 2; s <= 4; s++) step(1'b1, 1'b0, 8'h00, 1'b0, 3'(s), 1'b1);

    // Flush together with en and valid input: flush wins.
    step(1'b1, 1'b1, 8'h77, 1'b1, 3'd1, 1'b1);
    for (int s = 1; s <= 5; s++) step(1'b0, 1'b0, 8'h77, 1'b1, 3'(s), 1'b1);

    // Tap sweep including out-of-range selects.
    for (int s = 0; s <= 7; s++) step(1'b0, 1'b0, 8'h5A, 1'b1, 3'(s), 1'b1);

    // Saturation, then invalid words draining the valids.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(i + 1), 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hEE, 1'b0, 3'd1, 1'b1);

    // Asynchronous reset mid-stream, then restart.
    step(1'b1, 1'b0, 8'h99, 1'b1, 3'd2, 1'b1);
    step(1'b1, 1'b0, 8'h98, 1'b1, 3'd1, 1'b0);
    step(1'b1, 1'b0, 8'h97, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 8'($urandom),
           ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 63) != 0));
    end

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #5;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_chain.md
# tap_chain

Parametrised delay line built from STAGES chained instances of a per-stage register submodule, connected by port name in a generate loop. It is the multi-stage, multi-bit successor to our single-instance hierarchy blocks. It adds a shift enable, per-stage valid tracking, a synchronous flush, a fill counter and a runtime-selectable output tap. It sits between a producer stream and any consumer that needs a programmable 0..STAGES cycle delay.

## Interface
- WIDTH, 8: data width per stage, 1..64.
- STAGES, 4: number of register stages, 1..16.
- SEL_W, $clog2(STAGES+1): width of sel and fill; derived, not overridden.
- clk  input  1  rising-edge clock.
- resetn  input  1  reset, asynchronous, active-low.
- en  input  1  shift enable; chain advances only on cycles with en=1.
- flush  input  1  synchronous flush; clears valids and fill.
- d  input  WIDTH  input data.
- d_valid  input  1  input data valid.
- sel  input  SEL_W  tap select; 0 = input pass-through, k = output of stage k (1..STAGES).
- q  output  WIDTH  selected tap data (combinational from sel and state).
- q_valid  output  1  selected tap valid.
- fill  output  SEL_W  number of valid-shift cycles since reset/flush, saturating at STAGES.
- full  output  1  fill == STAGES.

## Operation
- Structure: stage k (1..STAGES) is one submodule instance holding data_k[WIDTH-1:0] and v_k.
  - Stage 1 input is {d_valid, d}.
  - Stage k input is stage k-1 output.
  - All instances share clk, resetn and a common load strobe.
- Reset (resetn=0, asynchronous): all data_k=0, v_k=0, fill=0.
  - Consequently full=0, and q=0 / q_valid=0 for any sel >= 1.
- Priority each rising edge: flush > en > hold.
- flush=1:
  - All v_k <= 0 and fill <= 0.
  - data_k retain their values; en is ignored that cycle.
- flush=0, en=1: every stage loads its input simultaneously (one-cycle shift).
- fill on a cycle with flush=0, en=1 and d_valid=1:
  - fill <= min(fill+1, STAGES).
- fill on en=1 with d_valid=0:
  - fill unchanged, because fill counts accepted valid words, not cycles.
- flush=0, en=0: all state held.
- Tap mux:
  - sel=0: q=d, q_valid=d_valid (zero-latency bypass).
  - 1<=sel<=STAGES: q=data_sel, q_valid=v_sel.
  - sel>STAGES (possible when STAGES+1 is not a power of two): q=0, q_valid=0.
- full is a pure decode of fill; no separate register.

## Timing
- Latency from d to q is exactly sel enabled cycles; stalled (en=0) cycles add no advance.
- Outputs q/q_valid are combinational from sel, so a sel change takes effect in the same cycle.
- fill/full update on the clock edge following the qualifying cycle.
- Simultaneous flush and en with d_valid=1: the flush wins.
  - d is not captured as valid, and fill=0 next cycle.
  - data_k are not shifted on that edge.
- fill saturation: at fill=STAGES, further valid shifts keep fill=STAGES and full=1.
- Reset asserted mid-stream: immediate clear of all valids and fill, with no clock required.
  - On deassertion, the first edge behaves as from the empty state.
- STAGES=1 edge case:
  - SEL_W=1.
  - sel=1 selects the only stage.
  - full asserts after the first valid shift.

## Test plan
- Reset: WIDTH=8, STAGES=4, drive d=8'hFF, d_valid=1, resetn=0 without clock.
  - Required: q=0, q_valid=0 for sel=1..4; fill=0; full=0.
- Delay: en=1, feed 8'h11, 8'h22, 8'h33, 8'h44 with d_valid=1, sel=3.
  - Required: 8'h11 appears on q with q_valid=1 exactly 3 edges after its capture.
  - Required: fill reaches 4 and full=1 after the 4th edge.
- Stall: after loading 8'hA5, hold en=0 for 5 cycles.
  - Required: q, q_valid and fill are unchanged throughout.
  - Required: with en=1 restored, the shift resumes one stage per edge.
- Flush vs enable: flush=1, en=1, d_valid=1, d=8'h77 in the same cycle.
  - Required next cycle: all q_valid=0 for sel=1..4, fill=0, data not shifted.
- Tap sweep: sel=0 with d=8'h5A, d_valid=1.
  - Required: q=8'h5A combinationally.
  - With STAGES=5 (SEL_W=3), sel=6 and sel=7 are required to give q=0, q_valid=0.
- Saturation/invalid input:
  - 10 valid shifts with STAGES=4 leave fill=4.
  - Subsequent shifts with d_valid=0 leave fill=4 while q_valid at sel=1 goes 0 one edge later.
